// File: rtl/sysarray44_feeder.sv
// Operand sequencer for the 4x4 output-stationary systolic array: holds A/B,
// clears the array, then streams both matrices diagonally skewed onto its edges.
module sysarray44_feeder #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              array_rst,
    output logic [DATA_W-1:0] out_west0,
    output logic [DATA_W-1:0] out_west4,
    output logic [DATA_W-1:0] out_west8,
    output logic [DATA_W-1:0] out_west12,
    output logic [DATA_W-1:0] out_north0,
    output logic [DATA_W-1:0] out_north1,
    output logic [DATA_W-1:0] out_north2,
    output logic [DATA_W-1:0] out_north3
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(6);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(9);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [15:0][DATA_W-1:0] a_buf, b_buf;
    logic [3:0][DATA_W-1:0]  west_nx, north_nx, west_q, north_q;
    logic                    feed_nx, busy_nx, done_nx, arst_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = FEED;
                cnt_nx   = '0;
            end
            FEED: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == FEED_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every edge value is registered.
    always_comb begin
        feed_nx = (state_nx == FEED);
        busy_nx = (state_nx == CLEAR) || (state_nx == FEED) || (state_nx == DRAIN);
        done_nx = (state_nx == DONE);
        arst_nx = (state_nx == CLEAR);
    end

    // Lane l carries element k = c - l: row l of A to the west, column l of B north.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [CNT_W:0] k;
        logic           hit;
        assign k           = {1'b0, cnt_nx} - (CNT_W+1)'(l);
        assign hit         = feed_nx && ({1'b0, cnt_nx} >= (CNT_W+1)'(l))
                             && (k <= (CNT_W+1)'(3));
        assign west_nx[l]  = hit ? a_buf[{2'(l), k[1:0]}] : '0;
        assign north_nx[l] = hit ? b_buf[{k[1:0], 2'(l)}] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (state == IDLE && wr_en) begin
            if (wr_sel) b_buf[wr_addr] <= wr_data;
            else        a_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            array_rst <= 1'b1;
            west_q    <= '0;
            north_q   <= '0;
        end else begin
            busy      <= busy_nx;
            done      <= done_nx;
            array_rst <= arst_nx;
            west_q    <= west_nx;
            north_q   <= north_nx;
        end
    end

    assign out_west0  = west_q[0];
    assign out_west4  = west_q[1];
    assign out_west8  = west_q[2];
    assign out_west12 = west_q[3];
    assign out_north0 = north_q[0];
    assign out_north1 = north_q[1];
    assign out_north2 = north_q[2];
    assign out_north3 = north_q[3];

endmodule

// File: tb/tb_sysarray44_feeder.sv
// Bench for sysarray44_feeder with a behavioural 4x4 output-stationary array on its edges.
module tb_sysarray44_feeder;
    localparam int DATA_W = 32;

    logic              clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0]        wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              busy, done, array_rst;
    logic [DATA_W-1:0] out_west0, out_west4, out_west8, out_west12;
    logic [DATA_W-1:0] out_north0, out_north1, out_north2, out_north3;

    always #5 clk = ~clk;

    sysarray44_feeder #(.DATA_W(DATA_W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .array_rst(array_rst),
        .out_west0(out_west0), .out_west4(out_west4), .out_west8(out_west8),
        .out_west12(out_west12), .out_north0(out_north0), .out_north1(out_north1),
        .out_north2(out_north2), .out_north3(out_north3)
    );

    logic [3:0][31:0] west_v, north_v;
    assign west_v  = {out_west12, out_west8, out_west4, out_west0};
    assign north_v = {out_north3, out_north2, out_north1, out_north0};

    // Behavioural array: operands hop one PE per cycle east/south, each PE accumulates.
    logic [31:0] acc [4][4];
    logic [31:0] ar  [4][4];
    logic [31:0] br  [4][4];

    function automatic logic [31:0] a_in(int i, int j);
        return (j == 0) ? west_v[i] : ar[i][j-1];
    endfunction
    function automatic logic [31:0] b_in(int i, int j);
        return (i == 0) ? north_v[j] : br[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc[i][j] <= array_rst ? 32'h0 : acc[i][j] + a_in(i, j) * b_in(i, j);
                ar[i][j]  <= array_rst ? 32'h0 : a_in(i, j);
                br[i][j]  <= array_rst ? 32'h0 : b_in(i, j);
            end
    end

    typedef struct { logic [3:0][31:0] w; logic [3:0][31:0] n; } feed_t;
    feed_t       feed_q[$];
    logic [31:0] res_q[$];
    logic [31:0] ma[16], mb[16];
    int          checks = 0, errors = 0;

    task automatic wr(input bit sel, input int addr, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
        if (sel) mb[addr] = d; else ma[addr] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic push_expected();
        feed_t       f;
        logic [31:0] s;
        for (int c = 0; c < 7; c++) begin
            for (int l = 0; l < 4; l++) begin
                f.w[l] = (c - l >= 0 && c - l <= 3) ? ma[4*l + c - l]   : 32'h0;
                f.n[l] = (c - l >= 0 && c - l <= 3) ? mb[4*(c - l) + l] : 32'h0;
            end
            feed_q.push_back(f);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += ma[4*i + k] * mb[4*k + j];
                res_q.push_back(s);
            end
    endtask

    // One run from start; inject_c / abort_c pick a FEED cycle for protocol abuse or reset.
    task automatic run(input string name, input int inject_c, input int abort_c, input bit same_wr);
        feed_t       f;
        logic [31:0] e;
        int          ndone, nrst;
        if (same_wr) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 32'd3; mb[0] = 32'd3;
        end
        push_expected();
        start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; nrst = 0;
        for (int t = 1; t <= 14; t++) begin
            start = 1'b0; wr_en = 1'b0;
            if (array_rst) nrst++;
            if (done) ndone++;
            checks++;
            if (done !== (t == 12)) begin
                errors++; $display("FAIL %s done t=%0d got %b exp %b", name, t, done, t == 12);
            end
            checks++;
            if (busy !== (t <= 11)) begin
                errors++; $display("FAIL %s busy t=%0d got %b exp %b", name, t, busy, t <= 11);
            end
            if (t >= 2 && t <= 8) begin
                f = feed_q.pop_front();
                checks++;
                if (west_v !== f.w) begin
                    errors++; $display("FAIL %s west c=%0d got %h exp %h", name, t - 2, west_v, f.w);
                end
                checks++;
                if (north_v !== f.n) begin
                    errors++; $display("FAIL %s north c=%0d got %h exp %h", name, t - 2, north_v, f.n);
                end
                if (t - 2 == abort_c) begin
                    rst = 1'b1; #1;
                    checks++;
                    if ({west_v, north_v} !== '0 || busy !== 1'b0 || done !== 1'b0 || array_rst !== 1'b1) begin
                        errors++;
                        $display("FAIL %s abort outs=%h busy=%b done=%b arst=%b exp 0/0/0/1",
                                 name, {west_v, north_v}, busy, done, array_rst);
                    end
                    @(posedge clk); #1;
                    checks++;
                    if (acc[0][0] !== 0 || acc[3][3] !== 0 || acc[1][2] !== 0) begin
                        errors++; $display("FAIL %s abort_clear acc00=%0d acc33=%0d exp 0", name, acc[0][0], acc[3][3]);
                    end
                    rst = 1'b0;
                    for (int n = 0; n < 16; n++) begin
                        @(posedge clk); #1;
                        checks++;
                        if (done !== 1'b0) begin
                            errors++; $display("FAIL %s abort_done n=%0d got %b exp 0", name, n, done);
                        end
                    end
                    feed_q.delete(); res_q.delete();
                    for (int i = 0; i < 16; i++) begin ma[i] = 0; mb[i] = 0; end
                    return;
                end
                if (t - 2 == inject_c) begin
                    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'd9;
                end
            end
            if (t == 1 || (t >= 9 && t <= 12)) begin
                checks++;
                if ({west_v, north_v} !== '0) begin
                    errors++; $display("FAIL %s idle_outs t=%0d got %h exp 0", name, t, {west_v, north_v});
                end
            end
            if (t == 12) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        e = res_q.pop_front();
                        checks++;
                        if (acc[i][j] !== e) begin
                            errors++; $display("FAIL %s result(%0d,%0d) got %0d exp %0d", name, i, j, acc[i][j], e);
                        end
                    end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ndone != 1 || nrst != 1) begin
            errors++; $display("FAIL %s pulses done=%0d arst=%0d exp 1/1", name, ndone, nrst);
        end
        feed_q.delete(); res_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || array_rst !== 1'b1) begin
            errors++; $display("FAIL reset ctl busy=%b done=%b arst=%b exp 0/0/1", busy, done, array_rst);
        end
        checks++;
        if ({west_v, north_v} !== '0) begin
            errors++; $display("FAIL reset outs got %h exp 0", {west_v, north_v});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (array_rst !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release arst=%b busy=%b exp 0/0", array_rst, busy);
        end
    endtask

    task automatic load_skew(input logic [31:0] off);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) wr(0, 4*i + k, 32'h10*i + k + off);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) wr(1, 4*k + j, 32'h100 + 32'h10*k + j + off);
    endtask

    task automatic test_skew();
        load_skew(0);
        run("skew", -1, -1, 0);
    endtask

    task automatic test_identity();
        for (int i = 0; i < 16; i++) wr(0, i, (i % 5 == 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < 16; i++) wr(1, i, i + 1);
        run("identity", -1, -1, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) wr(0, i, 32'd5);
        for (int i = 0; i < 16; i++) wr(1, i, 32'd7);
        run("full", -1, -1, 0);
    endtask

    task automatic test_protocol();
        run("protocol", 2, -1, 0);
        run("rerun", -1, -1, 0);
    endtask

    task automatic test_back_to_back();
        int dt[$];
        start = 1'b1;
        for (int n = 0; n < 40 && dt.size() < 2; n++) begin
            @(posedge clk); #1;
            if (done) dt.push_back(n);
        end
        start = 1'b0;
        checks++;
        if (dt.size() != 2) begin
            errors++; $display("FAIL b2b dones got %0d exp 2", dt.size());
        end else begin
            checks++;
            if (dt[1] - dt[0] != 13) begin
                errors++; $display("FAIL b2b spacing got %0d exp 13", dt[1] - dt[0]);
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b settle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        run("abort", -1, 4, 0);
        load_skew(32'h7);
        run("after_abort", -1, -1, 0);
    endtask

    task automatic test_same_cycle();
        run("same_cycle", -1, -1, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin ma[i] = 0; mb[i] = 0; end
        test_reset();
        test_skew();
        test_identity();
        test_full();
        test_protocol();
        test_back_to_back();
        test_reset_mid();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
